// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// using a single full-subtractor cell and a borrow flop. A result takes
// WIDTH+1 cycles after the accept edge (WIDTH RUN cycles plus one DONE cycle).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; operands are captured on the accept edge
// RUN    | one bit per cycle through the full-subtractor step
// DONE   | diff/borrow just updated; done pulses for this single cycle
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             bit_d;
    logic             bit_bo;
    logic [WIDTH-1:0] sd_shift;

    // Single-bit full-subtractor cell on the current LSBs plus carried borrow.
    always_comb begin
        bit_d    = sa_q[0] ^ sb_q[0] ^ br_q;
        bit_bo   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        sd_shift = {bit_d, sd_q[WIDTH-1:1]};
    end

    // Next-state and datapath update; the last RUN bit goes straight into diff.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = sd_shift;
                br_d  = bit_bo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    diff_d   = sd_shift;
                    borrow_d = bit_bo;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset also clears the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=5.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start5;
    logic [7:0] a8, b8, diff8;
    logic [4:0] a5, b5, diff5;
    logic       busy8, done8, borrow8;
    logic       busy5, done5, borrow5;

    int checks   = 0;
    int failures = 0;
    int pulses8  = 0;
    int pulses5  = 0;
    int overlap  = 0;
    int ops8     = 0;
    int ops5     = 0;
    logic [7:0] exp_last_d8 = 8'h00;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5),
        .busy(busy5), .done(done5), .diff(diff5), .borrow(borrow5)
    );

    // Pulse and busy/done exclusivity monitors.
    always @(negedge clk) begin
        if (done8) pulses8++;
        if (done5) pulses5++;
        if ((busy8 && done8) || (busy5 && done5)) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation; DUT must be idle on entry.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
        int bc;
        bc = 0;
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~av; b8 = bv ^ 8'h5A;
        check("w8_diff_hold", diff8, exp_last_d8);
        for (int i = 0; i < 8; i++) begin
            if (busy8 && !done8) bc++;
            @(negedge clk);
        end
        check("w8_busy_cycles", bc, 8);
        check("w8_done_pulse", {busy8, done8}, 2'b01);
        check("w8_diff", diff8, ed);
        check("w8_borrow", borrow8, eb);
        exp_last_d8 = ed;
        ops8++;
        @(negedge clk);
        check("w8_done_drop", {busy8, done8}, 2'b00);
    endtask

    // One WIDTH=5 operation with a bounded wait for done.
    task automatic do_op5(input logic [4:0] av, input logic [4:0] bv);
        int n;
        logic [4:0] ed;
        ed = av - bv;
        n = 0;
        @(negedge clk);
        a5 = av; b5 = bv; start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0; a5 = ~av; b5 = ~bv;
        while (!done5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w5_latency", n, 5);
        check("w5_diff", diff5, ed);
        check("w5_borrow", borrow5, av < bv);
        ops5++;
        @(negedge clk);
    endtask

    initial begin
        int prev, nd, dcount;
        logic [7:0] ra, rb;
        rst = 1'b1; start8 = 1'b0; start5 = 1'b0;
        a8 = '0; b8 = '0; a5 = '0; b5 = '0;
        repeat (3) @(negedge clk);
        check("rst_w8", {busy8, done8, diff8, borrow8}, 11'h0);
        check("rst_w5", {busy5, done5, diff5, borrow5}, 8'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {busy8, done8, busy5, done5}, 4'h0);

        do_op8(8'h05, 8'h03, 8'h02, 1'b0);
        do_op8(8'h03, 8'h05, 8'hFE, 1'b1);
        do_op8(8'h00, 8'h01, 8'hFF, 1'b1);
        do_op8(8'hFF, 8'hFF, 8'h00, 1'b0);
        do_op8(8'h80, 8'h7F, 8'h01, 1'b0);

        // start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'h0A; b8 = 8'h04; start8 = 1'b1;
        prev = -1; nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done8) begin
                check("held_diff", diff8, 8'h06);
                if (prev >= 0) check("held_period", c - prev, 10);
                prev = c;
                nd++;
            end
            if (busy8) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end else begin
                a8 = 8'h0A;
                b8 = 8'h04;
            end
        end
        start8 = 1'b0;
        check("held_ops", nd, 4);
        ops8 += nd;
        exp_last_d8 = 8'h06;
        @(negedge clk);

        // Reset on the 4th RUN cycle aborts the operation.
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {busy8, done8, diff8, borrow8}, 11'h0);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) dcount++;
        end
        check("abort_no_done", dcount, 0);
        exp_last_d8 = 8'h00;
        do_op8(8'h05, 8'h03, 8'h02, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op8(ra, rb, ra - rb, ra < rb);
        end

        do_op5(5'h00, 5'h01);
        do_op5(5'h1F, 5'h1F);
        for (int i = 0; i < 1000; i++) begin
            do_op5(5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
        end

        repeat (2) @(negedge clk);
        check("w8_pulse_count", pulses8, ops8);
        check("w5_pulse_count", pulses5, ops5);
        check("busy_done_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
